// File: rtl/int_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : int_ctrl_pkg
// Shared FSM encoding and constants for interrupt_controller.
// Rev    : 1.0
// ============================================================================
package int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] IRQ_NONE = 2'd0;
  localparam int         MAX_SRC  = 3;

endpackage
`default_nettype wire

// File: rtl/irq_priority_enc.sv
`default_nettype none
// ============================================================================
// Module : irq_priority_enc
// Fixed-priority encoder: lowest set index wins.
// Rev    : 1.0
// ============================================================================
module irq_priority_enc
  import int_ctrl_pkg::*;
#(
  parameter int N = MAX_SRC
) (
  input  logic [N-1:0] eligible,
  output logic         valid,
  output logic [1:0]   index
);

  // Scan from the top down so the last hit is the lowest index.
  always_comb begin
    valid = 1'b0;
    index = 2'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        index = 2'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module : interrupt_controller
// Edge-latched multi-source interrupt controller with IACK/IEND handshake.
// Optional service timeout enabled by defining INT_TIMEOUT_EN.
// Rev    : 1.0
// ============================================================================
module interrupt_controller
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [NUM_SRC-1:0] SRC_REQ,
  input  logic [NUM_SRC-1:0] SRC_MASK,
  output logic [1:0]         INT_IRQ,
  input  logic               INT_IACK,
  input  logic               INT_IEND,
  output logic [NUM_SRC-1:0] SRC_ACK,
  output logic [NUM_SRC-1:0] PENDING,
  output logic               INT_ERROR
);

  state_t             r_state;
  state_t             w_stateNext;
  logic [NUM_SRC-1:0] r_reqQ;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] r_srcAck;
  logic [NUM_SRC-1:0] w_srcAckNext;
  logic [NUM_SRC-1:0] w_pendClr;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_eligible;
  logic [NUM_SRC-1:0] w_curOneHot;
  logic [1:0]         r_curId;
  logic [1:0]         w_curIdNext;
  logic [1:0]         r_irq;
  logic [1:0]         w_irqNext;
  logic [1:0]         w_winIdx;
  logic               w_winValid;
  logic               w_curMasked;
  logic               w_timerExpired;

  assign w_rise      = SRC_REQ & ~r_reqQ;
  assign w_eligible  = r_pending & ~SRC_MASK;
  assign w_curOneHot = NUM_SRC'(1) << r_curId;
  assign w_curMasked = |(SRC_MASK & w_curOneHot);

  irq_priority_enc #(
    .N (NUM_SRC)
  ) u_prioEnc (
    .eligible (w_eligible),
    .valid    (w_winValid),
    .index    (w_winIdx)
  );

`ifdef INT_TIMEOUT_EN
  localparam logic [15:0] c_timeoutLast = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_timer;
  logic        r_error;

  // Timer idles at zero outside SERVICE, so it reads zero on entry.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_timer <= '0;
    end else if (r_state != SERVICE) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + 16'd1;
    end
  end

  assign w_timerExpired = (r_state == SERVICE) && (r_timer == c_timeoutLast);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_error <= 1'b0;
    end else if (w_timerExpired && !INT_IEND) begin
      r_error <= 1'b1;
    end
  end

  assign INT_ERROR = r_error;
`else
  localparam int c_unusedTimeoutCyc = TIMEOUT_CYC;

  assign w_timerExpired = 1'b0;
  assign INT_ERROR      = 1'b0;
`endif

  always_comb begin
    w_stateNext  = r_state;
    w_curIdNext  = r_curId;
    w_irqNext    = r_irq;
    w_srcAckNext = '0;
    w_pendClr    = '0;
    case (r_state)
      IDLE: begin
        w_irqNext = IRQ_NONE;
        if (w_winValid) begin
          w_curIdNext = w_winIdx;
          w_irqNext   = w_winIdx + 2'd1;
          w_stateNext = ASSERT;
        end
      end
      ASSERT: begin
        // An acknowledge in the same cycle as a mask change still wins.
        if (INT_IACK) begin
          w_pendClr    = w_curOneHot;
          w_srcAckNext = w_curOneHot;
          w_irqNext    = IRQ_NONE;
          w_stateNext  = SERVICE;
        end else if (w_curMasked) begin
          w_irqNext   = IRQ_NONE;
          w_stateNext = IDLE;
        end
      end
      SERVICE: begin
        w_irqNext = IRQ_NONE;
        if (INT_IEND || w_timerExpired) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_irqNext   = IRQ_NONE;
        w_stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= IDLE;
      r_curId   <= 2'd0;
      r_irq     <= IRQ_NONE;
      r_srcAck  <= '0;
      r_reqQ    <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_stateNext;
      r_curId   <= w_curIdNext;
      r_irq     <= w_irqNext;
      r_srcAck  <= w_srcAckNext;
      r_reqQ    <= SRC_REQ;
      // A new edge on the bit being acknowledged keeps it pending.
      r_pending <= (r_pending & ~w_pendClr) | w_rise;
    end
  end

  assign INT_IRQ = r_irq;
  assign SRC_ACK = r_srcAck;
  assign PENDING = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module : tb_interrupt_controller
// Scoreboard bench for interrupt_controller against a transaction-level model.
// Rev    : 1.0
// ============================================================================
module tb_interrupt_controller;

  localparam int NSRC       = 3;
  localparam int TB_TIMEOUT = 8;

  typedef struct {
    logic [2:0] val;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [2:0] pend;
    logic       err;
    int         cyc;
  } st_t;

  logic            CLK      = 1'b0;
  logic            RESET    = 1'b1;
  logic [NSRC-1:0] SRC_REQ  = '0;
  logic [NSRC-1:0] SRC_MASK = '0;
  logic            INT_IACK = 1'b0;
  logic            INT_IEND = 1'b0;
  logic [1:0]      INT_IRQ;
  logic [NSRC-1:0] SRC_ACK;
  logic [NSRC-1:0] PENDING;
  logic            INT_ERROR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  ev_t irqQ[$];
  ev_t ackQ[$];
  st_t statQ[$];

  // Reference model: which source is on offer, whether one is in service.
  logic [2:0] mPend      = '0;
  logic [2:0] mPrevReq   = '0;
  int         mOffered   = -1;
  int         mSvcCyc    = 0;
  bit         mBusy      = 1'b0;
  bit         mErr       = 1'b0;
  logic [1:0] mIrq       = '0;
  logic [1:0] mIrqBefore = '0;

  interrupt_controller #(
    .NUM_SRC     (NSRC),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .SRC_REQ   (SRC_REQ),
    .SRC_MASK  (SRC_MASK),
    .INT_IRQ   (INT_IRQ),
    .INT_IACK  (INT_IACK),
    .INT_IEND  (INT_IEND),
    .SRC_ACK   (SRC_ACK),
    .PENDING   (PENDING),
    .INT_ERROR (INT_ERROR)
  );

  always #5 CLK = ~CLK;

  task automatic model_step();
    logic [2:0] rise;
    logic [1:0] newIrq;
    int         clr;
    rise = SRC_REQ & ~mPrevReq;
    clr  = -1;
    if (mOffered >= 0) begin
      if (INT_IACK) begin
        clr = mOffered;
        ackQ.push_back('{3'(1 << mOffered), cyc});
        mBusy    = 1'b1;
        mSvcCyc  = 0;
        mOffered = -1;
      end else if (SRC_MASK[mOffered]) begin
        mOffered = -1;
      end
    end else if (mBusy) begin
      if (INT_IEND) begin
        mBusy = 1'b0;
      end
`ifdef INT_TIMEOUT_EN
      else if (mSvcCyc == TB_TIMEOUT - 1) begin
        mErr  = 1'b1;
        mBusy = 1'b0;
      end else begin
        mSvcCyc++;
      end
`endif
    end else begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        if (mPend[i] && !SRC_MASK[i]) mOffered = i;
      end
    end
    for (int i = 0; i < NSRC; i++) begin
      if (i == clr) mPend[i] = 1'b0;
      if (rise[i])  mPend[i] = 1'b1;
    end
    mPrevReq = SRC_REQ;
    newIrq   = (mOffered >= 0) ? 2'(mOffered + 1) : 2'd0;
    if (newIrq != mIrq) irqQ.push_back('{{1'b0, newIrq}, cyc});
    mIrq = newIrq;
  endtask

  // Called just after an edge: anything the model predicted for this cycle
  // is wiped out by the asynchronous reset before it can be observed.
  task automatic model_reset();
    while (irqQ.size() > 0 && irqQ[irqQ.size()-1].cyc >= cyc) void'(irqQ.pop_back());
    while (ackQ.size() > 0 && ackQ[ackQ.size()-1].cyc >= cyc) void'(ackQ.pop_back());
    if (mIrqBefore != 2'd0) irqQ.push_back('{3'd0, cyc});
    if (statQ.size() > 0 && statQ[statQ.size()-1].cyc == cyc) begin
      void'(statQ.pop_back());
      statQ.push_back('{3'd0, 1'b0, cyc});
    end
    mPend      = '0;
    mPrevReq   = '0;
    mOffered   = -1;
    mSvcCyc    = 0;
    mBusy      = 1'b0;
    mErr       = 1'b0;
    mIrq       = 2'd0;
    mIrqBefore = 2'd0;
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    mIrqBefore = mIrq;
    if (!RESET) model_step();
    statQ.push_back('{mPend, mErr, cyc});
    #1;
  endtask

  task automatic cyc_in(logic [2:0] r, logic [2:0] m, bit a, bit e);
    SRC_REQ  = r;
    SRC_MASK = m;
    INT_IACK = a;
    INT_IEND = e;
    tick();
  endtask

  task automatic idle(int n, logic [2:0] r, logic [2:0] m);
    repeat (n) cyc_in(r, m, 1'b0, 1'b0);
  endtask

  task automatic do_reset(int n);
    INT_IACK = 1'b0;
    INT_IEND = 1'b0;
    RESET    = 1'b1;
    model_reset();
    repeat (n) tick();
    RESET = 1'b0;
  endtask

  // Monitor: pops expectations as the DUT presents changes.
  initial begin
    logic [1:0] lastIrq;
    ev_t        e;
    st_t        s;
    lastIrq = 2'd0;
    forever begin
      @(negedge CLK);
      if (cyc > 0) begin
        if (INT_IRQ !== lastIrq) begin
          checks++;
          if (irqQ.size() == 0) begin
            failures++;
            $display("FAIL irq_unexpected cyc=%0d got=%0d exp=none", cyc, INT_IRQ);
          end else begin
            e = irqQ.pop_front();
            if (e.val[1:0] !== INT_IRQ || e.cyc != cyc) begin
              failures++;
              $display("FAIL irq cyc=%0d got=%0d exp=%0d@%0d", cyc, INT_IRQ, e.val[1:0], e.cyc);
            end
          end
          lastIrq = INT_IRQ;
        end else if (irqQ.size() > 0 && irqQ[0].cyc <= cyc) begin
          checks++;
          failures++;
          e = irqQ.pop_front();
          $display("FAIL irq_missing cyc=%0d got=%0d exp=%0d@%0d", cyc, INT_IRQ, e.val[1:0], e.cyc);
        end

        if (SRC_ACK !== 3'b000) begin
          checks++;
          if (ackQ.size() == 0) begin
            failures++;
            $display("FAIL src_ack_unexpected cyc=%0d got=%b exp=000", cyc, SRC_ACK);
          end else begin
            e = ackQ.pop_front();
            if (e.val !== SRC_ACK || e.cyc != cyc) begin
              failures++;
              $display("FAIL src_ack cyc=%0d got=%b exp=%b@%0d", cyc, SRC_ACK, e.val, e.cyc);
            end
          end
        end else if (ackQ.size() > 0 && ackQ[0].cyc <= cyc) begin
          checks++;
          failures++;
          e = ackQ.pop_front();
          $display("FAIL src_ack_missing cyc=%0d got=000 exp=%b@%0d", cyc, e.val, e.cyc);
        end

        checks++;
        if (statQ.size() == 0) begin
          failures++;
          $display("FAIL status_missing cyc=%0d", cyc);
        end else begin
          s = statQ.pop_front();
          if (s.cyc != cyc || PENDING !== s.pend || INT_ERROR !== s.err) begin
            failures++;
            $display("FAIL status cyc=%0d pending=%b error=%b exp pending=%b error=%b@%0d",
                     cyc, PENDING, INT_ERROR, s.pend, s.err, s.cyc);
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] r;
    logic [2:0] m;
    bit         a;
    bit         e;
    int         idx;

    do_reset(3);
    idle(20, 3'b000, 3'b000);

    // Source 0 full handshake with the documented timing.
    cyc_in(3'b001, 3'b000, 1'b0, 1'b0);
    idle(3, 3'b001, 3'b000);
    cyc_in(3'b001, 3'b000, 1'b1, 1'b0);
    idle(3, 3'b001, 3'b000);
    cyc_in(3'b001, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);

    // Sources 0 and 2 together: 0 first, then 2.
    cyc_in(3'b101, 3'b000, 1'b0, 1'b0);
    idle(3, 3'b101, 3'b000);
    cyc_in(3'b101, 3'b000, 1'b1, 1'b0);
    idle(2, 3'b101, 3'b000);
    cyc_in(3'b101, 3'b000, 1'b0, 1'b1);
    idle(3, 3'b101, 3'b000);
    cyc_in(3'b101, 3'b000, 1'b1, 1'b0);
    idle(2, 3'b101, 3'b000);
    cyc_in(3'b101, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);

    // Masked source latches but is withheld until unmasked.
    cyc_in(3'b001, 3'b001, 1'b0, 1'b0);
    idle(4, 3'b001, 3'b001);
    idle(3, 3'b001, 3'b000);
    cyc_in(3'b001, 3'b000, 1'b1, 1'b0);
    idle(2, 3'b001, 3'b000);
    cyc_in(3'b001, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);

    // Masking an offered source withdraws it; IACK+IEND together in ASSERT.
    cyc_in(3'b010, 3'b000, 1'b0, 1'b0);
    idle(3, 3'b010, 3'b000);
    idle(2, 3'b010, 3'b010);
    idle(3, 3'b010, 3'b000);
    cyc_in(3'b010, 3'b000, 1'b1, 1'b1);
    idle(2, 3'b010, 3'b000);
    cyc_in(3'b010, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);

    // Re-edge during service re-raises the same source; stray IACK/IEND ignored.
    cyc_in(3'b010, 3'b000, 1'b0, 1'b0);
    idle(3, 3'b010, 3'b000);
    cyc_in(3'b010, 3'b000, 1'b1, 1'b0);
    cyc_in(3'b000, 3'b000, 1'b0, 1'b0);
    cyc_in(3'b010, 3'b000, 1'b0, 1'b0);
    cyc_in(3'b010, 3'b000, 1'b0, 1'b1);
    idle(3, 3'b010, 3'b000);
    cyc_in(3'b010, 3'b000, 1'b1, 1'b0);
    idle(2, 3'b010, 3'b000);
    cyc_in(3'b010, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);
    cyc_in(3'b000, 3'b000, 1'b1, 1'b0);
    idle(2, 3'b000, 3'b000);
    cyc_in(3'b000, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);

    // New edge in the same cycle as its acknowledge: stays pending.
    cyc_in(3'b001, 3'b000, 1'b0, 1'b0);
    idle(3, 3'b001, 3'b000);
    cyc_in(3'b000, 3'b000, 1'b0, 1'b0);
    cyc_in(3'b001, 3'b000, 1'b1, 1'b0);
    idle(2, 3'b001, 3'b000);
    cyc_in(3'b001, 3'b000, 1'b0, 1'b1);
    idle(3, 3'b001, 3'b000);
    cyc_in(3'b001, 3'b000, 1'b1, 1'b0);
    cyc_in(3'b001, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);

    // Reset mid-handshake drops everything.
    cyc_in(3'b110, 3'b000, 1'b0, 1'b0);
    idle(3, 3'b110, 3'b000);
    do_reset(2);
    idle(3, 3'b110, 3'b000);
    cyc_in(3'b110, 3'b000, 1'b1, 1'b0);
    idle(2, 3'b110, 3'b000);
    cyc_in(3'b110, 3'b000, 1'b0, 1'b1);
    idle(3, 3'b000, 3'b000);
    cyc_in(3'b000, 3'b000, 1'b1, 1'b0);
    cyc_in(3'b000, 3'b000, 1'b0, 1'b1);
    idle(2, 3'b000, 3'b000);

`ifdef INT_TIMEOUT_EN
    // Service never ended: timeout flag, then cleared by reset.
    cyc_in(3'b100, 3'b000, 1'b0, 1'b0);
    idle(3, 3'b100, 3'b000);
    cyc_in(3'b100, 3'b000, 1'b1, 1'b0);
    idle(12, 3'b100, 3'b000);
    do_reset(2);
    idle(3, 3'b000, 3'b000);
`endif

    for (int n = 0; n < 1500; n++) begin
      r = SRC_REQ;
      m = SRC_MASK;
      if ($urandom_range(0, 7) == 0) begin
        idx = $urandom_range(0, 2);
        r[idx] = ~r[idx];
      end
      if ($urandom_range(0, 15) == 0) begin
        idx = $urandom_range(0, 2);
        m[idx] = ~m[idx];
      end
      a = (mOffered >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      e = mBusy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 399) == 0) begin
        SRC_REQ  = r;
        SRC_MASK = m;
        do_reset(2);
      end else begin
        cyc_in(r, m, a, e);
      end
    end

    idle(4, SRC_REQ, SRC_MASK);
    @(negedge CLK);
    #1;
    checks++;
    if (irqQ.size() != 0) begin
      failures++;
      $display("FAIL irq_leftover got=%0d pending expectations exp=0", irqQ.size());
    end
    checks++;
    if (ackQ.size() != 0) begin
      failures++;
      $display("FAIL src_ack_leftover got=%0d pending expectations exp=0", ackQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
